lpc_host_sequencer: RTL and testbench
=====================================

// Module: lpc_host_sequencer
// PURPOSE
//  Transaction front-end directly upstream of the LPC host FSM. Accepts queued I/O/memory read/write requests
//  on a valid/ready port, drives the host's ctrl_* inputs with the framing/status sequence, and detects completion
//  (ctrl_ready rising), sync error (host enters FORCE_RESET) or timeout. Returns one response per request;
//  sequences LPC reset at power-up and after errors.
// PARAMETERS
//  FIFO_AW         2    request FIFO depth = 2**FIFO_AW entries of {mem,wr,addr[15:0],data[7:0]} (26 bits)
//  TIMEOUT_CYCLES  256  max clk_i cycles from frame start to completion; counter width $clog2(TIMEOUT_CYCLES+1)
//  RST_CYCLES      8    cycles ctrl_nrst_o held low per reset sequence (>=1)
// PORTS
//  clk_i               in   1   clock; same clock as LPC host FSM
//  nrst_i              in   1   asynchronous active-low reset
//  req_valid_i         in   1   request valid
//  req_ready_o         out  1   request accepted when valid&ready; = !fifo_full
//  req_wr_i            in   1   1 write, 0 read
//  req_mem_i           in   1   1 memory cycle, 0 I/O cycle
//  req_addr_i          in   16  LPC address
//  req_data_i          in   8   write data (ignored for reads)
//  resp_valid_o        out  1   response valid; held until resp_ready_i
//  resp_ready_i        in   1   response consumed
//  resp_data_o         out  8   read data; 8'h00 for writes and errors
//  resp_status_o       out  2   00 OK, 01 SYNC_ERR, 10 TIMEOUT
//  busy_o              out  1   1 whenever FSM != SQ_IDLE or FIFO non-empty
//  ctrl_addr_o         out  16  -> host ctrl_addr_i;  ctrl_data_o out 8 -> host ctrl_data_i
//  ctrl_nrst_o         out  1   -> host ctrl_nrst_i;  ctrl_lframe_o out 1 -> host ctrl_lframe_i (active low)
//  ctrl_rd_status_o    out  1   -> host ctrl_rd_status_i;  ctrl_wr_status_o out 1 -> host ctrl_wr_status_i
//  ctrl_memory_cycle_o out  1   -> host ctrl_memory_cycle_i
//  ctrl_data_i         in   8   <- host ctrl_data_o (read data, valid when ctrl_ready_i rises)
//  ctrl_ready_i        in   1   <- host ctrl_ready_o (level; set at completion, cleared on next START)
//  ctrl_host_state_i   in   5   <- host ctrl_host_state_o (`LPC_ST_* encodings)
// BEHAVIOUR
//  Reset (nrst_i=0): FIFO empty, state SQ_RESET, rst count 0, ctrl_nrst_o=0, ctrl_lframe_o=1, rd/wr status=0,
//   ctrl_addr_o=0, ctrl_data_o=0, ctrl_memory_cycle_o=0, resp_valid_o=0, resp_data_o=0, resp_status_o=0, ready_q=0.
//  All outputs registered. ready_q <= ctrl_ready_i every cycle; done = ctrl_ready_i & ~ready_q.
//  SQ_RESET: ctrl_nrst_o=0 for RST_CYCLES cycles, then ctrl_nrst_o=1 -> SQ_IDLE.
//  SQ_IDLE: if FIFO non-empty and host_state==`LPC_ST_IDLE: pop head into ctrl_* regs, ctrl_lframe_o=0,
//   clear timeout counter -> SQ_FRAME. Else hold.
//  SQ_FRAME (1 cycle): ctrl_lframe_o=1, ctrl_rd_status_o=~wr, ctrl_wr_status_o=wr -> SQ_WAIT.
//  SQ_WAIT: status/addr/data held stable; counter increments each cycle. Priority per cycle:
//   1 host_state==`LPC_ST_FORCE_RESET -> status 01, data 00, -> SQ_RESP, then SQ_RESET.
//   2 done -> status 00, resp_data_o = wr ? 00 : ctrl_data_i, -> SQ_RESP, then SQ_IDLE.
//   3 counter==TIMEOUT_CYCLES -> status 10, data 00, -> SQ_RESP, then SQ_DRAIN.
//   Leaving SQ_WAIT clears rd/wr status.
//  SQ_RESP: resp_valid_o=1 until resp_ready_i; then next state as recorded. No new frame while response pending.
//  SQ_DRAIN: wait host_state==`LPC_ST_IDLE (late done ignored) -> SQ_IDLE, or FORCE_RESET -> SQ_RESET.
//  FIFO: push on req_valid_i&req_ready_o, pop in SQ_IDLE; push+pop same cycle allowed when not full;
//   full -> req_ready_o=0 even if popping that cycle; pointers FIFO_AW+1 bits, wrap naturally.
//  Latency: IDLE with empty FIFO -> ctrl_lframe_o low 2 cycles after accepted request.
//  Responses strictly in request order; exactly one response per accepted request.
//  nrst_i asserted mid-transaction: all state discarded, no response, FIFO flushed.
// STRUCTURE
//  Sequencer state encodings and status codes (LPC_SQ_*, LPC_RESP_OK/SYNC_ERR/TIMEOUT) go in shared lpc_defines.v
//  next to `LPC_ST_*. One sub-module: lpc_req_fifo (param width/depth, sync, async reset, full/empty).
// TESTING (bench: lpc_host_sequencer + lpc_host + LPC peripheral BFM on LAD)
//  I/O read 0x0080, BFM sync 0000 data A5 -> resp status 00 data A5; LAD cyctype 0000.
//  Mem write 0x1234 data 3C -> cyctype 0110, BFM sees 3C; resp status 00 data 00.
//  BFM answers sync 1010 -> host FORCE_RESET; resp status 01; ctrl_nrst_o low 8 cycles; next request OK.
//  BFM holds sync 0110 forever, TIMEOUT_CYCLES=32 -> status 10 at 32nd cycle; sequencer remains in SQ_DRAIN.
//  Push 5 back-to-back with FIFO_AW=2, resp_ready_i low -> req_ready_o drops at 4 queued; 5 in-order responses.
//  nrst_i pulse during SQ_WAIT -> outputs at reset values, FIFO empty, no resp_valid_o.

Source files
------------

// File: rtl/lpc_host_sequencer_pkg.sv
// rtl/lpc_host_sequencer_pkg.sv - shared types and encodings for the LPC host sequencer
package lpc_host_sequencer_pkg;

  typedef enum logic [2:0] {
    SQ_RESET = 3'd0,
    SQ_IDLE  = 3'd1,
    SQ_FRAME = 3'd2,
    SQ_WAIT  = 3'd3,
    SQ_RESP  = 3'd4,
    SQ_DRAIN = 3'd5
  } sq_state_e;

  localparam logic [1:0] LPC_RESP_OK       = 2'b00;
  localparam logic [1:0] LPC_RESP_SYNC_ERR = 2'b01;
  localparam logic [1:0] LPC_RESP_TIMEOUT  = 2'b10;

  // Host FSM state codes the sequencer reacts to.
  localparam logic [4:0] LPC_ST_IDLE        = 5'h00;
  localparam logic [4:0] LPC_ST_FORCE_RESET = 5'h10;

  typedef struct packed {
    logic        mem;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } lpc_req_t;

  localparam int REQ_W = $bits(lpc_req_t);

endpackage

// File: rtl/lpc_req_fifo.sv
// rtl/lpc_req_fifo.sv - synchronous request FIFO with full/empty flags
module lpc_req_fifo #(
  parameter int WIDTH = 26,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lpc_host_sequencer.sv
// rtl/lpc_host_sequencer.sv - request front-end driving the LPC host FSM control inputs
module lpc_host_sequencer
  import lpc_host_sequencer_pkg::*;
#(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int RST_CYCLES     = 8
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic        req_mem_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [7:0]  resp_data_o,
  output logic [1:0]  resp_status_o,
  output logic        busy_o,
  output logic [15:0] ctrl_addr_o,
  output logic [7:0]  ctrl_data_o,
  output logic        ctrl_nrst_o,
  output logic        ctrl_lframe_o,
  output logic        ctrl_rd_status_o,
  output logic        ctrl_wr_status_o,
  output logic        ctrl_memory_cycle_o,
  input  logic [7:0]  ctrl_data_i,
  input  logic        ctrl_ready_i,
  input  logic [4:0]  ctrl_host_state_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_ONE   = RST_W'(1);

  sq_state_e        state_q, state_d;
  sq_state_e        after_resp_q, after_resp_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             ready_q;
  logic             wr_q, wr_d;
  logic             nrst_q, nrst_d;
  logic             lframe_q, lframe_d;
  logic             rd_st_q, rd_st_d;
  logic             wr_st_q, wr_st_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             mem_q, mem_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       resp_data_q, resp_data_d;
  logic [1:0]       resp_status_q, resp_status_d;

  logic             done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [REQ_W-1:0] fifo_rdata;
  lpc_req_t         req_in;
  lpc_req_t         head;

  assign req_in = '{mem: req_mem_i, wr: req_wr_i, addr: req_addr_i, data: req_data_i};
  assign head   = fifo_rdata;

  lpc_req_fifo #(
    .WIDTH (REQ_W),
    .AW    (FIFO_AW)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (req_valid_i & ~fifo_full),
    .wdata_i (req_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The host holds ctrl_ready as a level; only its rising edge marks completion.
  assign done    = ctrl_ready_i & ~ready_q;
  assign tmo_inc = tmo_cnt_q + TMO_ONE;

  always_comb begin
    state_d       = state_q;
    after_resp_d  = after_resp_q;
    rst_cnt_d     = rst_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    wr_d          = wr_q;
    nrst_d        = nrst_q;
    lframe_d      = lframe_q;
    rd_st_d       = rd_st_q;
    wr_st_d       = wr_st_q;
    addr_d        = addr_q;
    data_d        = data_q;
    mem_d         = mem_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      SQ_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          nrst_d    = 1'b1;
          rst_cnt_d = '0;
          state_d   = SQ_IDLE;
        end else begin
          nrst_d    = 1'b0;
          rst_cnt_d = rst_cnt_q + RST_ONE;
        end
      end
      SQ_IDLE: begin
        if (!fifo_empty && ctrl_host_state_i == LPC_ST_IDLE) begin
          fifo_pop  = 1'b1;
          addr_d    = head.addr;
          data_d    = head.data;
          mem_d     = head.mem;
          wr_d      = head.wr;
          lframe_d  = 1'b0;
          tmo_cnt_d = '0;
          state_d   = SQ_FRAME;
        end
      end
      SQ_FRAME: begin
        lframe_d  = 1'b1;
        rd_st_d   = ~wr_q;
        wr_st_d   = wr_q;
        tmo_cnt_d = tmo_inc;
        state_d   = SQ_WAIT;
      end
      SQ_WAIT: begin
        tmo_cnt_d = tmo_inc;
        if (ctrl_host_state_i == LPC_ST_FORCE_RESET) begin
          resp_status_d = LPC_RESP_SYNC_ERR;
          resp_data_d   = 8'h00;
          after_resp_d  = SQ_RESET;
          state_d       = SQ_RESP;
        end else if (done) begin
          resp_status_d = LPC_RESP_OK;
          resp_data_d   = wr_q ? 8'h00 : ctrl_data_i;
          after_resp_d  = SQ_IDLE;
          state_d       = SQ_RESP;
        end else if (tmo_inc >= TMO_LIMIT) begin
          resp_status_d = LPC_RESP_TIMEOUT;
          resp_data_d   = 8'h00;
          after_resp_d  = SQ_DRAIN;
          state_d       = SQ_RESP;
        end
        if (state_d == SQ_RESP) begin
          resp_valid_d = 1'b1;
          rd_st_d      = 1'b0;
          wr_st_d      = 1'b0;
        end
      end
      SQ_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = after_resp_q;
          if (after_resp_q == SQ_RESET) begin
            nrst_d    = 1'b0;
            rst_cnt_d = '0;
          end
        end
      end
      SQ_DRAIN: begin
        // A completion arriving after the timeout is deliberately dropped here.
        if (ctrl_host_state_i == LPC_ST_FORCE_RESET) begin
          nrst_d    = 1'b0;
          rst_cnt_d = '0;
          state_d   = SQ_RESET;
        end else if (ctrl_host_state_i == LPC_ST_IDLE) begin
          state_d = SQ_IDLE;
        end
      end
      default: begin
        nrst_d    = 1'b0;
        rst_cnt_d = '0;
        state_d   = SQ_RESET;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q       <= SQ_RESET;
      after_resp_q  <= SQ_IDLE;
      rst_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      ready_q       <= 1'b0;
      wr_q          <= 1'b0;
      nrst_q        <= 1'b0;
      lframe_q      <= 1'b1;
      rd_st_q       <= 1'b0;
      wr_st_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      mem_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      after_resp_q  <= after_resp_d;
      rst_cnt_q     <= rst_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      ready_q       <= ctrl_ready_i;
      wr_q          <= wr_d;
      nrst_q        <= nrst_d;
      lframe_q      <= lframe_d;
      rd_st_q       <= rd_st_d;
      wr_st_q       <= wr_st_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mem_q         <= mem_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign req_ready_o         = ~fifo_full;
  assign busy_o              = (state_q != SQ_IDLE) | ~fifo_empty;
  assign resp_valid_o        = resp_valid_q;
  assign resp_data_o         = resp_data_q;
  assign resp_status_o       = resp_status_q;
  assign ctrl_addr_o         = addr_q;
  assign ctrl_data_o         = data_q;
  assign ctrl_nrst_o         = nrst_q;
  assign ctrl_lframe_o       = lframe_q;
  assign ctrl_rd_status_o    = rd_st_q;
  assign ctrl_wr_status_o    = wr_st_q;
  assign ctrl_memory_cycle_o = mem_q;

endmodule

// File: tb/tb_lpc_host_sequencer.sv
// tb/tb_lpc_host_sequencer.sv - randomized self-checking bench with a behavioural LPC host model
module tb_lpc_host_sequencer;
  import lpc_host_sequencer_pkg::*;

  localparam int FIFO_AW = 2;
  localparam int TMO     = 32;
  localparam int RSTC    = 8;
  localparam logic [4:0] HOST_BUSY = 5'h03;

  logic        clk = 1'b0;
  logic        nrst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wr_i = 1'b0;
  logic        req_mem_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [7:0]  req_data_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [7:0]  resp_data_o;
  logic [1:0]  resp_status_o;
  logic        busy_o;
  logic [15:0] ctrl_addr_o;
  logic [7:0]  ctrl_data_o;
  logic        ctrl_nrst_o;
  logic        ctrl_lframe_o;
  logic        ctrl_rd_status_o;
  logic        ctrl_wr_status_o;
  logic        ctrl_memory_cycle_o;
  logic [7:0]  host_data = '0;
  logic        host_ready = 1'b0;
  logic [4:0]  host_state = LPC_ST_IDLE;

  always #5 clk = ~clk;

  lpc_host_sequencer #(
    .FIFO_AW        (FIFO_AW),
    .TIMEOUT_CYCLES (TMO),
    .RST_CYCLES     (RSTC)
  ) dut (
    .clk_i               (clk),
    .nrst_i              (nrst_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_wr_i            (req_wr_i),
    .req_mem_i           (req_mem_i),
    .req_addr_i          (req_addr_i),
    .req_data_i          (req_data_i),
    .resp_valid_o        (resp_valid_o),
    .resp_ready_i        (resp_ready_i),
    .resp_data_o         (resp_data_o),
    .resp_status_o       (resp_status_o),
    .busy_o              (busy_o),
    .ctrl_addr_o         (ctrl_addr_o),
    .ctrl_data_o         (ctrl_data_o),
    .ctrl_nrst_o         (ctrl_nrst_o),
    .ctrl_lframe_o       (ctrl_lframe_o),
    .ctrl_rd_status_o    (ctrl_rd_status_o),
    .ctrl_wr_status_o    (ctrl_wr_status_o),
    .ctrl_memory_cycle_o (ctrl_memory_cycle_o),
    .ctrl_data_i         (host_data),
    .ctrl_ready_i        (host_ready),
    .ctrl_host_state_i   (host_state)
  );

  typedef struct {
    logic        mem;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } req_s;

  typedef struct {
    logic [1:0] status;
    logic [7:0] data;
  } resp_s;

  typedef enum {H_IDLE, H_BUSY, H_FORCE} hmode_e;

  req_s   req_q[$];
  resp_s  exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     n_acc = 0;
  int     n_resp = 0;
  int     n_dropped = 0;
  int     force_outcome = 1;
  int     rr_pct = 70;
  hmode_e hmode = H_IDLE;
  int     hcnt = 0;
  int     hout = 0;
  bit     first = 1'b0;
  int     low_run = 0;
  req_s   cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral read data is a fixed function of the cycle address.
  function automatic logic [7:0] rd_value(input logic mem, input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ (mem ? 8'hC3 : 8'h5A);
  endfunction

  function automatic int pick_outcome();
    int r;
    r = int'($urandom_range(99, 0));
    if (r < 70) return 1;
    if (r < 85) return 2;
    return 3;
  endfunction

  // Host + peripheral model and response scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    resp_ready_i = (int'($urandom_range(99, 0)) < rr_pct);
    if (resp_valid_o && resp_ready_i) begin : resp_chk
      resp_s e;
      if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("resp_status", resp_status_o, e.status);
        chk("resp_data", resp_data_o, e.data);
        n_resp++;
      end
    end

    if (!nrst_i) low_run = 0;
    else if (!ctrl_nrst_o) low_run++;
    else if (low_run != 0) begin
      chk("nrst_low_cycles", low_run, RSTC);
      low_run = 0;
    end

    if (!ctrl_nrst_o) begin
      hmode      = H_IDLE;
      host_state = LPC_ST_IDLE;
      host_ready = 1'b0;
    end else begin
      case (hmode)
        H_IDLE: if (!ctrl_lframe_o) begin
          if (req_q.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            cur = req_q.pop_front();
            chk("frame_fields", {ctrl_memory_cycle_o, ctrl_addr_o, ctrl_data_o},
                {cur.mem, cur.addr, cur.data});
            hout = (force_outcome != 0) ? force_outcome : pick_outcome();
            hcnt = (hout == 3) ? TMO + 10 : int'($urandom_range(12, 1));
            case (hout)
              1:       exp_q.push_back('{status: LPC_RESP_OK,
                                         data: cur.wr ? 8'h00 : rd_value(cur.mem, cur.addr)});
              2:       exp_q.push_back('{status: LPC_RESP_SYNC_ERR, data: 8'h00});
              default: exp_q.push_back('{status: LPC_RESP_TIMEOUT, data: 8'h00});
            endcase
            host_ready = 1'b0;
            host_state = HOST_BUSY;
            hmode      = H_BUSY;
            first      = 1'b1;
          end
        end
        H_BUSY: begin
          if (first) begin
            chk("status_strobes", {ctrl_rd_status_o, ctrl_wr_status_o, ctrl_lframe_o},
                {~cur.wr, cur.wr, 1'b1});
            first = 1'b0;
          end
          hcnt--;
          if (hcnt == 0) begin
            if (hout == 2) begin
              host_state = LPC_ST_FORCE_RESET;
              hmode      = H_FORCE;
            end else begin
              host_state = LPC_ST_IDLE;
              host_ready = 1'b1;
              host_data  = cur.wr ? 8'hEE : rd_value(cur.mem, cur.addr);
              hmode      = H_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  task automatic push_req(input logic m, input logic w, input logic [15:0] a, input logic [7:0] d);
    int g;
    g = 0;
    req_valid_i = 1'b1;
    req_mem_i   = m;
    req_wr_i    = w;
    req_addr_i  = a;
    req_data_i  = d;
    while (!req_ready_o && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) chk("req_accept_timeout", 1, 0);
    else begin
      req_q.push_back('{mem: m, wr: w, addr: a, data: d});
      n_acc++;
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!(exp_q.size() == 0 && req_q.size() == 0 && !busy_o && hmode == H_IDLE) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_nrst_release();
    int g;
    g = 0;
    while (!ctrl_nrst_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("nrst_release_timeout", 1, 0);
  endtask

  initial begin
    int g;
    int cnt;
    #1 nrst_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctrl_nrst", ctrl_nrst_o, 0);
    chk("rst_lframe", ctrl_lframe_o, 1);
    chk("rst_strobes", {ctrl_rd_status_o, ctrl_wr_status_o, ctrl_memory_cycle_o}, 0);
    chk("rst_ctrl_addr_data", {ctrl_addr_o, ctrl_data_o}, 0);
    chk("rst_resp", {resp_valid_o, resp_data_o, resp_status_o}, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 1);
    nrst_i = 1'b1;
    @(negedge clk);
    wait_nrst_release();
    @(negedge clk);
    chk("idle_busy", busy_o, 0);

    force_outcome = 1;
    rr_pct = 100;
    push_req(1'b0, 1'b0, 16'h0080, 8'h00);
    wait_idle();
    push_req(1'b1, 1'b1, 16'h1234, 8'h3C);
    wait_idle();

    force_outcome = 2;
    push_req(1'b0, 1'b0, 16'h0060, 8'h11);
    wait_idle();
    force_outcome = 1;
    push_req(1'b0, 1'b0, 16'h0061, 8'h22);
    wait_idle();

    force_outcome = 3;
    push_req(1'b1, 1'b0, 16'hBEEF, 8'h00);
    g = 0;
    while (ctrl_lframe_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    cnt = 0;
    while (!resp_valid_o && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_latency", cnt, TMO);
    repeat (3) @(negedge clk);
    chk("drain_busy", busy_o, 1);
    force_outcome = 1;
    wait_idle();

    rr_pct = 0;
    for (int i = 0; i < 5; i++)
      push_req(1'b0, 1'($urandom_range(1, 0)), 16'h0300 + 16'(i), 8'($urandom));
    repeat (20) @(negedge clk);
    chk("fifo_full_ready", req_ready_o, 0);
    chk("resp_held", resp_valid_o, 1);
    rr_pct = 70;
    wait_idle();

    force_outcome = 0;
    for (int i = 0; i < 60; i++) begin
      rr_pct = int'($urandom_range(100, 40));
      push_req(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 16'($urandom), 8'($urandom));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    rr_pct = 80;
    wait_idle();

    rr_pct = 0;
    force_outcome = 3;
    for (int i = 0; i < 3; i++) push_req(1'b0, 1'b1, 16'h0400 + 16'(i), 8'h55);
    g = 0;
    while (hmode != H_BUSY && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #2;
    nrst_i = 1'b0;
    n_dropped += req_q.size() + exp_q.size();
    req_q.delete();
    exp_q.delete();
    #1;
    chk("midrst_resp_valid", resp_valid_o, 0);
    chk("midrst_req_ready", req_ready_o, 1);
    chk("midrst_ctrl", {ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o, ctrl_wr_status_o}, 4'b0100);
    @(posedge clk);
    #2;
    nrst_i = 1'b1;
    force_outcome = 1;
    rr_pct = 70;
    @(negedge clk);
    wait_nrst_release();
    @(negedge clk);
    chk("midrst_flushed", {busy_o, resp_valid_o}, 0);
    push_req(1'b0, 1'b0, 16'h0099, 8'h00);
    wait_idle();

    chk("resp_count", n_resp, n_acc - n_dropped);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
